// File: rtl/sseg_bin_display.sv
// Binary (unsigned or two's complement) to multiplexed seven-segment display engine.
// Latency: WIDTH+1 cycles from accepted load to done; refresh free-runs at REFRESH_DIV cycles per digit.
// Backpressure: load accepted only while busy=0; loads during a conversion are dropped, not queued.
module sseg_bin_display #(
    parameter int WIDTH       = 9,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic              signed_mode,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [6:0]        SSeg,
    output logic [DIGITS-1:0] an
);
    function automatic int dec_digits(input int v);
        int n;
        int t;
        n = 1;
        t = v / 10;
        while (t > 0) begin
            n = n + 1;
            t = t / 10;
        end
        return n;
    endfunction

    localparam int BCD_NEED = dec_digits((1 << WIDTH) - 1);
    // At least DIGITS nibbles so every display position has a BCD source.
    localparam int NB       = (BCD_NEED > DIGITS) ? BCD_NEED : DIGITS;
    localparam int BW       = NB * 4;
    localparam int CNT_W    = $clog2(WIDTH);
    localparam int REF_W    = $clog2(REFRESH_DIV);
    localparam int IDX_W    = $clog2(DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]         mag_q, mag_d;
    logic [BW-1:0]            bcd_q, bcd_d;
    logic                     sign_q, sign_d;
    logic                     smode_q, smode_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic [DIGITS-1:0][6:0]   disp_q, disp_d;
    logic [REF_W-1:0]         ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0]        an_q, an_d;
    logic [6:0]               sseg_q, sseg_d;

    logic [BW-1:0]            bcd_adj;
    logic [BW-1:0]            bcd_next;
    logic [WIDTH-1:0]         mag_next;
    logic                     ovf_c;
    logic [DIGITS-1:0][6:0]   commit_disp;
    logic                     load_sign;
    logic                     wrap;

    // One double-dabble step: correct nibbles, then shift the next magnitude bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_next = (bcd_adj << 1) | {{(BW-1){1'b0}}, mag_q[WIDTH-1]};
        mag_next = mag_q << 1;
    end

    // Symbols for the commit edge, built from the finished BCD register.
    always_comb begin
        int n_avail;
        int msd;
        n_avail     = smode_q ? (DIGITS - 1) : DIGITS;
        ovf_c       = 1'b0;
        msd         = 0;
        commit_disp = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= n_avail && bcd_q[i*4 +: 4] != 4'd0) begin
                ovf_c = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                msd = i;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_c) begin
                commit_disp[i] = SEG_MINUS;
            end else if (i <= msd) begin
                commit_disp[i] = seg_code(bcd_q[i*4 +: 4]);
            end else begin
                commit_disp[i] = SEG_BLANK;
            end
        end
        if (!ovf_c && smode_q) begin
            commit_disp[DIGITS-1] = sign_q ? SEG_MINUS : SEG_BLANK;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        smode_d   = smode_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        disp_d    = disp_q;
        load_sign = signed_mode & value[WIDTH-1];
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    sign_d    = load_sign;
                    smode_d   = signed_mode;
                    mag_d     = load_sign ? (~value + 1'b1) : value;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d     = bcd_next;
                mag_d     = mag_next;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d  = commit_disp;
                ovf_d   = ovf_c;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Digit select and segment code change on the same edge; reading disp_d
    // lets a commit that lands on a wrap edge show up immediately.
    always_comb begin
        wrap      = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
        ref_cnt_d = wrap ? '0 : (ref_cnt_q + REF_W'(1));
        idx_d     = idx_q;
        an_d      = an_q;
        sseg_d    = sseg_q;
        if (wrap) begin
            idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : (idx_q + IDX_W'(1));
            an_d   = ~(DIGITS'(1) << idx_d);
            sseg_d = disp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            mag_q     <= '0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            smode_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            disp_q    <= {DIGITS{SEG_BLANK}};
            ref_cnt_q <= '0;
            idx_q     <= '0;
            an_q      <= ~DIGITS'(1);
            sseg_q    <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            smode_q   <= smode_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            disp_q    <= disp_d;
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign SSeg     = sseg_q;
    assign an       = an_q;
endmodule

// File: doc/sseg_bin_display.md
# sseg_bin_display

Parametrised binary-to-seven-segment display engine: it accepts a WIDTH-bit unsigned or two's-complement value through a load handshake. It converts the value to BCD sequentially (shift-add-3, one bit per clock), commits the digits atomically and time-multiplexes them onto DIGITS common-anode displays. It succeeds the fixed 4-digit, adder-driven display path and sits between any arithmetic datapath and the board's SSeg/an pins. It adds a signed mode, leading-zero blanking and overflow indication.

## Interface
- WIDTH, 9: input value width; legal range 4..16.
- DIGITS, 4: number of multiplexed displays; legal range 2..8.
- REFRESH_DIV, 50000: clk cycles each digit stays enabled; minimum 2.
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- value  input  WIDTH  number to display; sampled only on an accepted load.
- signed_mode  input  1  1: value is two's complement; sampled with value.
- load  input  1  request conversion; accepted when load=1 and busy=0.
- busy  output  1  conversion in progress; load is ignored while high.
- done  output  1  one-cycle pulse when new digits are committed.
- overflow  output  1  committed value did not fit; held until next commit.
- SSeg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  DIGITS  digit enables, active-low, one-hot; an[0] is the rightmost digit.

## Operation
- Capture (accepting edge): latch sign = signed_mode & value[WIDTH-1]; magnitude = sign ? (~value+1) : value, as WIDTH-bit unsigned. -2^(WIDTH-1) therefore yields magnitude 2^(WIDTH-1) correctly.
- Convert:
  - Internal BCD register holds enough digits for 2^WIDTH-1.
  - Each of WIDTH cycles: add 3 to every BCD nibble ≥5, then shift {bcd, mag} left 1.
- Available magnitude digits: N = DIGITS in unsigned mode, DIGITS-1 in signed mode. The leftmost digit is reserved for the sign in signed mode.
- Commit (atomic, single edge): display register receives one symbol per digit:
  - Overflow (any BCD digit at position ≥N nonzero): every digit shows minus; overflow=1.
  - Otherwise digit i shows its BCD value.
  - Leading-zero blanking: digits above the most significant nonzero digit are blank. Digit 0 always shows a value, so 0 displays as "0".
  - Signed mode, negative: the leftmost digit shows minus; otherwise it is blank. Overflow=0.
- The display register keeps showing the previous committed value throughout a conversion.
- Segment codes (active-low):
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - minus=0111111, blank=1111111.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→DIGITS-1→0.
  - an = ~(1<<index).
  - SSeg is the registered code of the indexed digit, updated on the same edge as an, so there is no ghosting between digits.
- FSM states:
  - IDLE: load → CONVERT.
  - CONVERT: WIDTH cycles → COMMIT.
  - COMMIT: one cycle → IDLE.
- Refresh logic runs independently of the FSM.

## Timing
- Reset values: busy=0, done=0, overflow=0, FSM=IDLE, all digits blank, refresh counter=0, index=0, an=~1, SSeg=1111111.
- Load accepted at edge t:
  - busy=1 after edges t..t+WIDTH.
  - At edge t+WIDTH+1: digits committed, done=1 for exactly one cycle, busy=0.
  - A new load is accepted at edge t+WIDTH+2 at the earliest. Latency is WIDTH+1 cycles.
- Load while busy=1: ignored and not queued; value changes during conversion have no effect.
- A committed value reaches SSeg when the corresponding digit is next indexed, within DIGITS·REFRESH_DIV cycles.
- Reset asserted mid-conversion: immediate return to the reset state. No partial commit occurs and no done pulse is generated.
- A commit edge coinciding with a refresh wrap: SSeg shows the new code for the new index.

## Test plan
- Reset, then hold: an=1110, SSeg=1111111, busy=0; after REFRESH_DIV cycles an=1101, SSeg still blank.
- Unsigned load 511 (WIDTH=9, DIGITS=4): busy high for 10 cycles, done pulse at cycle 10. Scan shows blank,5,1,1; digit 0 SSeg=1111001; overflow=0.
- Signed load 9'h100 (-256): scan shows minus,2,5,6 (digit 3 SSeg=0111111); unsigned 7 shows blank,blank,blank,7; value 0 shows blank ×3 then 1000000.
- DIGITS=2, unsigned 100: both digits show 0111111 and overflow=1; a following load of 99 shows 9,9 and clears overflow.
- Load pulsed again 3 cycles after an accepted load with a different value: ignored, and only the first value is committed. A load at cycle WIDTH+2 is accepted.
- Display 42, then load 123 and assert rst_n=0 at cycle 5: all digits blank, no done pulse, busy=0; after release, load 7 converts normally.
